// File: rtl/cmos_dvp_tx.sv
// -----------------------------------------------------------------------------
// cmos_dvp_tx
//
// Sensor-side DVP transmitter. Takes RGB565 pixels from a valid/ready stream
// and drives an 8-bit camera-style parallel bus (VSYNC, HREF, DATA), high byte
// first. Used as a sensor emulator for loopback bring-up of the capture chain
// and as the source for re-transmitting processed frames.
//
// Frame timing is fixed by parameters and never stretches for input stalls.
// When a pixel slot finds no valid input, FILL is sent and UNDERRUN latches.
//
// Optional feature (compile-time macro CMOS_TX_TESTPAT_EN):
//   defined   - iTEST_MODE=1 at frame start selects 8 internal colour bars.
//   undefined - iTEST_MODE is ignored and only the stream input is used.
//
// Ports
//   iCLK         in   bus clock, one byte per cycle (PCLK = iCLK)
//   iRST_N       in   synchronous active-low reset
//   iENABLE      in   run request, sampled in IDLE and at frame end
//   iTEST_MODE   in   colour-bar request (feature builds only)
//   iPIX_DATA    in   16-bit RGB565 pixel
//   iPIX_VALID   in   pixel available
//   oPIX_READY   out  pixel consumed this cycle if valid
//   oCMOS_VSYNC  out  high = sync / inter-frame
//   oCMOS_HREF   out  high while line bytes are on oCMOS_DATA
//   oCMOS_DATA   out  byte bus, 0 whenever HREF is low
//   oFRAME_CNT   out  completed frames, wraps
//   oUNDERRUN    out  sticky underrun flag
// -----------------------------------------------------------------------------
module cmos_dvp_tx #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_BLANK    = 144,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_SYNC_CYC = 3000,
  parameter int          V_BACK     = 17,
  parameter int          V_FRONT    = 10,
  parameter logic [15:0] FILL       = 16'h0000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iENABLE,
  input  logic        iTEST_MODE,
  input  logic [15:0] iPIX_DATA,
  input  logic        iPIX_VALID,
  output logic        oPIX_READY,
  output logic        oCMOS_VSYNC,
  output logic        oCMOS_HREF,
  output logic [7:0]  oCMOS_DATA,
  output logic [15:0] oFRAME_CNT,
  output logic        oUNDERRUN
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HREF_LEN = 2 * H_ACTIVE;
  localparam int V_MAX_AB = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
  localparam int V_MAX    = (V_MAX_AB > V_FRONT) ? V_MAX_AB : V_FRONT;

  localparam int HW = $clog2(LINE_LEN) + 1;
  localparam int SW = $clog2(V_SYNC_CYC) + 1;
  localparam int VW = $clog2(V_MAX) + 1;

  localparam logic [HW-1:0] H_LAST      = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] HREF_END    = HW'(HREF_LEN);
  localparam logic [HW-1:0] HREF_LAST   = HW'(HREF_LEN - 1);
  localparam logic [SW-1:0] SYNC_LAST   = SW'(V_SYNC_CYC - 1);
  localparam logic [VW-1:0] VACT_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VBACK_LAST  = VW'((V_BACK > 0) ? V_BACK - 1 : 0);
  localparam logic [VW-1:0] VFRONT_LAST = VW'((V_FRONT > 0) ? V_FRONT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  // Position of the current cycle on the bus; outputs are registered from
  // the position of the following cycle (nxt_*), so they line up exactly.
  state_t        state, nxt_state;
  logic [SW-1:0] sync_cnt, nxt_sync;
  logic [HW-1:0] h_cnt, nxt_h;
  logic [VW-1:0] v_cnt, nxt_v;
  logic          frame_done;
  logic          nxt_href;
  logic          pre_even;
  logic          take;
  logic          bars_on;
  logic [15:0]   bar_color;
  logic [15:0]   pix_word;
  logic [7:0]    lo_byte;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt_state  = state;
    nxt_sync   = sync_cnt;
    nxt_h      = h_cnt;
    nxt_v      = v_cnt;
    frame_done = 1'b0;

    case (state)
      S_IDLE: begin
        if (iENABLE) begin
          nxt_state = S_VSYNC;
          nxt_sync  = '0;
        end
      end
      S_VSYNC: begin
        if (sync_cnt == SYNC_LAST) begin
          nxt_h     = '0;
          nxt_v     = '0;
          nxt_state = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
        end else begin
          nxt_sync = sync_cnt + SW'(1);
        end
      end
      S_VBACK: begin
        if (h_cnt == H_LAST) begin
          nxt_h = '0;
          if (v_cnt == VBACK_LAST) begin
            nxt_v     = '0;
            nxt_state = S_ACTIVE;
          end else begin
            nxt_v = v_cnt + VW'(1);
          end
        end else begin
          nxt_h = h_cnt + HW'(1);
        end
      end
      S_ACTIVE: begin
        if (h_cnt == H_LAST) begin
          nxt_h = '0;
          if (v_cnt == VACT_LAST) begin
            nxt_v = '0;
            if (V_FRONT > 0) nxt_state = S_VFRONT;
            else             frame_done = 1'b1;
          end else begin
            nxt_v = v_cnt + VW'(1);
          end
        end else begin
          nxt_h = h_cnt + HW'(1);
        end
      end
      S_VFRONT: begin
        if (h_cnt == H_LAST) begin
          nxt_h = '0;
          if (v_cnt == VFRONT_LAST) begin
            nxt_v      = '0;
            frame_done = 1'b1;
          end else begin
            nxt_v = v_cnt + VW'(1);
          end
        end else begin
          nxt_h = h_cnt + HW'(1);
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    // iENABLE only matters here and in IDLE, so a frame is never cut short.
    if (frame_done) begin
      nxt_sync  = '0;
      nxt_state = iENABLE ? S_VSYNC : S_IDLE;
    end
  end

  // HREF in the next cycle, and whether that cycle is a high-byte slot.
  assign nxt_href = (nxt_state == S_ACTIVE) && (nxt_h < HREF_END);
  assign take     = nxt_href && !nxt_h[0];

  // True when the next cycle is the one immediately before a high-byte slot:
  // an odd slot that is not the last in the line, the last cycle before an
  // active line (previous line blank, last VBACK cycle, or last VSYNC cycle
  // when VBACK is skipped).
  always_comb begin
    pre_even = 1'b0;
    if (nxt_state == S_ACTIVE && nxt_h < HREF_END && nxt_h[0] && nxt_h != HREF_LAST)
      pre_even = 1'b1;
    if (nxt_state == S_ACTIVE && nxt_h == H_LAST && nxt_v != VACT_LAST)
      pre_even = 1'b1;
    if (nxt_state == S_VBACK && nxt_h == H_LAST && nxt_v == VBACK_LAST)
      pre_even = 1'b1;
    if (nxt_state == S_VSYNC && nxt_sync == SYNC_LAST && V_BACK == 0)
      pre_even = 1'b1;
  end

`ifdef CMOS_TX_TESTPAT_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int BW    = $clog2(BAR_W) + 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic          test_q;
  logic          frame_start;
  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx;

  assign frame_start = (nxt_state == S_VSYNC) && (state != S_VSYNC);
  // Mode is frozen for the whole frame once VSYNC starts.
  assign bars_on     = frame_start ? iTEST_MODE : test_q;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      test_q  <= 1'b0;
      bar_px  <= '0;
      bar_idx <= '0;
    end else begin
      if (frame_start) test_q <= iTEST_MODE;
      if (!nxt_href) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (take) begin
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + BW'(1);
        end
      end
    end
  end

  always_comb begin
    case (bar_idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = iTEST_MODE;
  assign bars_on          = 1'b0;
  assign bar_color        = 16'h0000;
`endif

  // Underrun substitutes FILL without moving the slot.
  assign pix_word = bars_on ? bar_color : (iPIX_VALID ? iPIX_DATA : FILL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is sampled synchronously on the edge.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state       <= S_IDLE;
      sync_cnt    <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      lo_byte     <= '0;
      oPIX_READY  <= 1'b0;
      oCMOS_VSYNC <= 1'b1;
      oCMOS_HREF  <= 1'b0;
      oCMOS_DATA  <= '0;
      oFRAME_CNT  <= '0;
      oUNDERRUN   <= 1'b0;
    end else begin
      state    <= nxt_state;
      sync_cnt <= nxt_sync;
      h_cnt    <= nxt_h;
      v_cnt    <= nxt_v;

      oCMOS_VSYNC <= (nxt_state == S_IDLE) || (nxt_state == S_VSYNC);
      oCMOS_HREF  <= nxt_href;
      oPIX_READY  <= pre_even && !bars_on;

      // High byte goes out the cycle after the handshake, low byte after it.
      if (take) begin
        oCMOS_DATA <= pix_word[15:8];
        lo_byte    <= pix_word[7:0];
      end else if (nxt_href) begin
        oCMOS_DATA <= lo_byte;
      end else begin
        oCMOS_DATA <= '0;
      end

      if (frame_done) oFRAME_CNT <= oFRAME_CNT + 16'd1;
      if (oPIX_READY && !iPIX_VALID) oUNDERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// -----------------------------------------------------------------------------
// tb_cmos_dvp_tx
//
// Directed bench for cmos_dvp_tx with a small frame (4x2 active, 3 blank
// cycles per line, 5 VSYNC cycles, 1 back and 1 front porch line). A per-cycle
// table of {drive inputs, expected bus outputs} is built for each frame from
// the frame timing and then applied and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_cmos_dvp_tx;

  localparam int          H_ACTIVE   = 4;
  localparam int          H_BLANK    = 3;
  localparam int          V_ACTIVE   = 2;
  localparam int          V_SYNC_CYC = 5;
  localparam int          V_BACK     = 1;
  localparam int          V_FRONT    = 1;
  localparam logic [15:0] FILL       = 16'h0000;

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;               // 11
  localparam int FRAME_LEN = V_SYNC_CYC + LINE_LEN * (V_BACK + V_ACTIVE + V_FRONT); // 49
  localparam int FIRST_ACT = V_SYNC_CYC + LINE_LEN * V_BACK + 1;   // 17

  logic        iCLK;
  logic        iRST_N;
  logic        iENABLE;
  logic        iTEST_MODE;
  logic [15:0] iPIX_DATA;
  logic        iPIX_VALID;
  logic        oPIX_READY;
  logic        oCMOS_VSYNC;
  logic        oCMOS_HREF;
  logic [7:0]  oCMOS_DATA;
  logic [15:0] oFRAME_CNT;
  logic        oUNDERRUN;

  cmos_dvp_tx #(
    .H_ACTIVE  (H_ACTIVE),
    .H_BLANK   (H_BLANK),
    .V_ACTIVE  (V_ACTIVE),
    .V_SYNC_CYC(V_SYNC_CYC),
    .V_BACK    (V_BACK),
    .V_FRONT   (V_FRONT),
    .FILL      (FILL)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iENABLE    (iENABLE),
    .iTEST_MODE (iTEST_MODE),
    .iPIX_DATA  (iPIX_DATA),
    .iPIX_VALID (iPIX_VALID),
    .oPIX_READY (oPIX_READY),
    .oCMOS_VSYNC(oCMOS_VSYNC),
    .oCMOS_HREF (oCMOS_HREF),
    .oCMOS_DATA (oCMOS_DATA),
    .oFRAME_CNT (oFRAME_CNT),
    .oUNDERRUN  (oUNDERRUN)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        valid;  // drive for the edge ending this cycle
    logic [15:0] pix;
    logic        vsync;  // expected outputs during this cycle
    logic        href;
    logic        ready;
    logic [7:0]  data;
  } vec_t;

  vec_t        tab [1:FRAME_LEN+1];
  logic [15:0] src [0:15];
  int          src_ptr;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cycle 1 is the first cycle after the edge that accepts iENABLE.
  // Cycles 1-5 VSYNC, 6-16 back porch, lines at 17 and 28 (8 HREF + 3 blank),
  // 39-49 front porch, cycle 50 VSYNC high again.
  // mask bit k: pixel k of the frame is offered as valid.
  task automatic build_frame(input logic [7:0] mask);
    int          c;
    int          k;
    logic [15:0] p;
    for (int i = 1; i <= FRAME_LEN + 1; i++)
      tab[i] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 1; i <= V_SYNC_CYC; i++) tab[i].vsync = 1'b1;
    tab[FRAME_LEN+1].vsync = 1'b1;
    for (int l = 0; l < V_ACTIVE; l++) begin
      for (int j = 0; j < H_ACTIVE; j++) begin
        c = FIRST_ACT + LINE_LEN * l + 2 * j;
        k = l * H_ACTIVE + j;
        tab[c-1].ready = 1'b1;
        tab[c-1].valid = mask[k];
        tab[c-1].pix   = src[src_ptr];
        if (mask[k]) begin
          p = src[src_ptr];
          src_ptr++;
        end else begin
          p = FILL;
        end
        tab[c].href   = 1'b1;
        tab[c].data   = p[15:8];
        tab[c+1].href = 1'b1;
        tab[c+1].data = p[7:0];
      end
    end
  endtask

  task automatic run_frame(input int first_c, input int frame_no, input int drop_c);
    logic [31:0] exp_cnt;
    for (int c = first_c; c <= FRAME_LEN + 1; c++) begin
      @(negedge iCLK);
      check($sformatf("f%0d_c%0d_bus", frame_no, c),
            {21'd0, oCMOS_VSYNC, oCMOS_HREF, oPIX_READY, oCMOS_DATA},
            {21'd0, tab[c].vsync, tab[c].href, tab[c].ready, tab[c].data});
      exp_cnt = (c <= FRAME_LEN) ? 32'(frame_no - 1) : 32'(frame_no);
      check($sformatf("f%0d_c%0d_frame_cnt", frame_no, c), {16'd0, oFRAME_CNT}, exp_cnt);
      if (c == drop_c) iENABLE = 1'b0;
      iPIX_VALID = tab[c].valid;
      iPIX_DATA  = tab[c].pix;
    end
  endtask

  initial begin
    logic found;
    checks     = 0;
    errors     = 0;
    src_ptr    = 0;
    for (int i = 0; i < 16; i++) src[i] = 16'h1234 + 16'(i) * 16'h4444;
    iRST_N     = 1'b0;
    iENABLE    = 1'b0;
    iTEST_MODE = 1'b0;
    iPIX_DATA  = 16'h0000;
    iPIX_VALID = 1'b0;

    // Reset held 3 cycles, then released with iENABLE low: idle bus.
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      check($sformatf("idle%0d_bus", i),
            {21'd0, oCMOS_VSYNC, oCMOS_HREF, oPIX_READY, oCMOS_DATA}, {21'd0, 3'b100, 8'h00});
      check($sformatf("idle%0d_cnt_urun", i), {15'd0, oFRAME_CNT, oUNDERRUN}, 32'd0);
    end

    // Frame 1: always valid, enable held, flows straight into frame 2.
    iENABLE = 1'b1;
    build_frame(8'hFF);
    run_frame(1, 1, 0);
    check("f1_underrun", {31'd0, oUNDERRUN}, 32'd0);

    // Frame 2: pixel 1 of line 0 missing, enable dropped mid-line 0.
    build_frame(8'hFD);
    run_frame(2, 2, 20);
    check("f2_underrun", {31'd0, oUNDERRUN}, 32'd1);

    // Back in IDLE: VSYNC stays high beyond the VSYNC length, no new frame.
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLK);
      check($sformatf("post_idle%0d", i),
            {21'd0, oCMOS_VSYNC, oCMOS_HREF, oPIX_READY, oCMOS_DATA}, {21'd0, 3'b100, 8'h00});
    end
    check("post_frame_cnt", {16'd0, oFRAME_CNT}, 32'd2);
    check("post_underrun_sticky", {31'd0, oUNDERRUN}, 32'd1);

    // Mid-frame reset during an HREF-high cycle.
    iENABLE    = 1'b1;
    iPIX_VALID = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge iCLK);
      if (oCMOS_HREF) found = 1'b1;
    end
    check("rst_href_seen", {31'd0, found}, 32'd1);
    iRST_N = 1'b0;
    @(negedge iCLK);
    check("rst_bus", {21'd0, oCMOS_VSYNC, oCMOS_HREF, oPIX_READY, oCMOS_DATA}, {21'd0, 3'b100, 8'h00});
    check("rst_cnt_urun", {15'd0, oFRAME_CNT, oUNDERRUN}, 32'd0);
    iENABLE = 1'b0;
    iRST_N  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLK);
      check($sformatf("rst_idle%0d", i),
            {21'd0, oCMOS_VSYNC, oCMOS_HREF, oPIX_READY, oCMOS_DATA}, {21'd0, 3'b100, 8'h00});
    end

`ifdef CMOS_TX_TESTPAT_EN
    // Colour bars: with H_ACTIVE=4 each bar is one pixel wide.
    begin
      logic [7:0] bar_bytes [0:7];
      logic       saw_ready;
      bar_bytes[0] = 8'hFF; bar_bytes[1] = 8'hFF;
      bar_bytes[2] = 8'hFF; bar_bytes[3] = 8'hE0;
      bar_bytes[4] = 8'h07; bar_bytes[5] = 8'hFF;
      bar_bytes[6] = 8'h07; bar_bytes[7] = 8'hE0;
      iTEST_MODE = 1'b1;
      iPIX_VALID = 1'b0;
      iENABLE    = 1'b1;
      found      = 1'b0;
      saw_ready  = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge iCLK);
        if (oPIX_READY) saw_ready = 1'b1;
        if (oCMOS_HREF) found = 1'b1;
      end
      check("bar_href_seen", {31'd0, found}, 32'd1);
      for (int i = 0; i < 8; i++) begin
        if (i > 0) @(negedge iCLK);
        if (oPIX_READY) saw_ready = 1'b1;
        check($sformatf("bar_byte%0d", i), {23'd0, oCMOS_HREF, oCMOS_DATA}, {23'd0, 1'b1, bar_bytes[i]});
      end
      check("bar_no_ready", {31'd0, saw_ready}, 32'd0);
      check("bar_no_underrun", {31'd0, oUNDERRUN}, 32'd0);
      iENABLE = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop well beyond the expected run length.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmos_dvp_tx.md
# cmos_dvp_tx

Sensor-side DVP transmitter: accepts 16-bit RGB565 pixels over a valid/ready stream and drives an 8-bit camera-style parallel bus (VSYNC, HREF, DATA), high byte first. It sits at the far end of the capture path. It serves as a sensor emulator for loopback bring-up of the binocular capture chain without physical cameras, and as the source for re-transmitting processed frames to a downstream DVP consumer. Frame geometry is fixed by parameters, and bus timing never depends on input stalls.

## Interface
- `H_ACTIVE`, 640, pixels per line (each pixel = 2 byte slots)
- `H_BLANK`, 144, HREF-low cycles after each line
- `V_ACTIVE`, 480, active lines per frame
- `V_SYNC_CYC`, 3000, VSYNC-high cycles per frame
- `V_BACK`, 17, blank lines between VSYNC fall and first active line
- `V_FRONT`, 10, blank lines after last active line
- `FILL`, 16'h0000, pixel emitted on underrun
- `iCLK` in 1: single clock; one bus byte per cycle; consumer samples on the same edge (PCLK = iCLK).
- `iRST_N` in 1: reset; synchronous, active-low.
- `iENABLE` in 1: run request; sampled only in IDLE and at frame end.
- `iTEST_MODE` in 1: select internal colour bars (see Configuration).
- `iPIX_DATA` in 16: RGB565 pixel.
- `iPIX_VALID` in 1: pixel available.
- `oPIX_READY` out 1: pixel consumed this cycle if valid.
- `oCMOS_VSYNC` out 1: high = sync/inter-frame; low = frame in progress.
- `oCMOS_HREF` out 1: high while a line's bytes are on `oCMOS_DATA`.
- `oCMOS_DATA` out 8: byte bus; 0 whenever HREF low.
- `oFRAME_CNT` out 16: completed frames, wraps at 65535→0.
- `oUNDERRUN` out 1: sticky; set when a pixel slot finds no valid input.

## Operation
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- IDLE: VSYNC=1, HREF=0, DATA=0, READY=0. Go to VSYNC when `iENABLE`=1.
- VSYNC: VSYNC=1 for exactly V_SYNC_CYC cycles → VBACK.
- VBACK: VSYNC=0, HREF=0 for V_BACK lines of `2*H_ACTIVE+H_BLANK` cycles → ACTIVE.
- ACTIVE: per line, HREF=1 for 2*H_ACTIVE cycles, then HREF=0 for H_BLANK. After V_ACTIVE lines → VFRONT.
- VFRONT: V_FRONT blank lines. Frame end: `oFRAME_CNT`+1. Go to VSYNC if `iENABLE`=1, else IDLE.
- Deasserting `iENABLE` mid-frame never truncates a frame.
- Byte order: even slot = pixel[15:8], odd slot = pixel[7:0].
- Pixel slot with READY=1 and VALID=0: FILL is emitted and `oUNDERRUN` is set. No retry and no timing shift. The next pixel is taken at the next slot.
- V_BACK or V_FRONT of 0 skips that state. Counters are sized by `$clog2` of each parameter + 1.

## Timing
- All outputs are registered.
- Reset values: VSYNC=1, HREF=0, DATA=0, READY=0, FRAME_CNT=0, UNDERRUN=0, state=IDLE.
- Reset mid-frame: outputs take reset values on the next edge. No partial frame resumes.
- `oPIX_READY`=1 in cycle t iff cycle t+1 is an even (high-byte) slot. It is therefore high for H_ACTIVE non-consecutive cycles per active line.
- Handshake at t: high byte on DATA at t+1, low byte at t+2.
- First HREF-high cycle follows the last VBACK cycle immediately. With V_BACK=0 it follows the last VSYNC-high cycle immediately.
- VSYNC rises on the cycle after the last VFRONT cycle, which is the edge the capture side counts as frame done. `oFRAME_CNT` updates on that same edge.

## Configuration
- `CMOS_TX_TESTPAT_EN` defined: when `iTEST_MODE`=1 (sampled at frame start), the pixel source is 8 vertical colour bars. Bar width is H_ACTIVE/8 pixels. Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. `oPIX_READY` stays 0 and `oUNDERRUN` is never set.
- `CMOS_TX_TESTPAT_EN` undefined: `iTEST_MODE` is ignored, and only the stream input is used.

## Test plan
Parameters: H_ACTIVE=4, H_BLANK=3, V_ACTIVE=2, V_SYNC_CYC=5, V_BACK=1, V_FRONT=1.

- Reset and enable: reset low 3 cycles, release with iENABLE=0 → VSYNC=1, HREF=0, DATA=0, READY=0 held. Raise iENABLE → VSYNC high 5 cycles, then low.
- Full frame, always-valid, pixels 16'h1234, 16'h5678, … → per line HREF high 8 cycles, low 3. DATA sequence 12,34,56,78,…. 2 active lines. FRAME_CNT=1 on the VSYNC rising edge, 5+11*4=49 cycles after start.
- Underrun: VALID low for the 2nd pixel of line 1 → bytes 00,00 in slots 3–4, UNDERRUN=1 sticky, line length still 8. The next pixel appears in slots 5–6.
- Disable mid-frame: drop iENABLE during line 1 → frame completes, FRAME_CNT increments, state returns to IDLE with VSYNC=1.
- Mid-frame reset: assert reset during an HREF-high cycle → next edge HREF=0, DATA=0, VSYNC=1, FRAME_CNT=0.
- Loopback, with `CMOS_TX_TESTPAT_EN` and iTEST_MODE=1: connect outputs to the capture block (PCLK=iCLK, Init_Done=1) → after the capture's frame-skip period, captured words equal the bar colours, with 16'hFFFF in the first H_ACTIVE/8 pixels.
